mem_access_stall_unit: RTL and testbench

- Parametrised successor of the EX/MEM access stage. Owns the inferred data RAM and a handshaked IO bridge port.
- Accepts one load/store per cycle from the pipeline and generates byte enables and aligned store data.
- Returns extracted, sign/zero-extended load data, and detects misalignment.
- Stalls the pipeline during multi-cycle IO transactions, which have a bounded timeout.

---
 rtl/mem_access_stall_unit_if.sv | 22 ++
 rtl/mem_access_stall_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_access_stall_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stall_unit_if.sv
// IO bridge bus of the memory access stage.
// The master side (the access unit) issues requests and the slave side
// (the IO bridge) completes them with io_ack and io_rdata.
interface mem_access_stall_unit_if;
   logic        io_req;
   logic        io_we;
   logic [29:0] io_addr;
   logic [31:0] io_wdata;
   logic [3:0]  io_be;
   logic        io_ack;
   logic [31:0] io_rdata;

   modport master (
      output io_req, io_we, io_addr, io_wdata, io_be,
      input  io_ack, io_rdata
   );

   modport slave (
      input  io_req, io_we, io_addr, io_wdata, io_be,
      output io_ack, io_rdata
   );
endinterface

// File: rtl/mem_access_stall_unit.sv
// Memory access stage: one load/store per cycle into the inferred data RAM,
// or a stalling, timeout-bounded transaction on the IO bridge bus.
// Produces byte enables, lane-aligned store data, extended load data and
// a misalignment pulse.
module mem_access_stall_unit #(
   parameter int unsigned DM_WORDS    = 4096,
   parameter logic [15:0] IO_BASE     = 16'h3000,
   parameter int unsigned TIMEOUT_CYC = 15
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    req_valid,
   input  logic                    mem_write,
   input  logic                    is_byte,
   input  logic                    is_half,
   input  logic                    is_unsigned,
   input  logic [31:0]             addr,
   input  logic [31:0]             wdata,
   output logic                    stall,
   output logic                    rdata_valid,
   output logic [31:0]             rdata,
   output logic                    align_err,
   mem_access_stall_unit_if.master io,
   output logic                    io_timeout
);

   localparam int unsigned DM_AW = $clog2(DM_WORDS);
   localparam int unsigned CW    = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, IO_BUSY, IO_DONE} state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

   // Selects the addressed byte/half of a word and extends it to 32 bits.
   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] o,
                                           input size_t s, input logic u);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{o, 3'b000} +: 8];
      h = w[{o[1], 4'b0000} +: 16];
      case (s)
         SZ_BYTE: return u ? {24'h0, b} : {{24{b[7]}}, b};
         SZ_HALF: return u ? {16'h0, h} : {{16{h[15]}}, h};
         default: return w;
      endcase
   endfunction

   // Request decode
   logic [1:0]       off;
   size_t            size;
   logic             misaligned;
   logic             in_dm;
   logic             accept;
   logic             dm_acc;
   logic             io_start;
   logic [3:0]       be;
   logic [31:0]      lane_data;
   logic [DM_AW-1:0] dm_idx;

   // Registered state
   state_t      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        to_q, to_d;
   logic        io_req_q, io_req_d;
   logic        io_we_q, io_we_d;
   logic [29:0] io_addr_q, io_addr_d;
   logic [31:0] io_wdata_q, io_wdata_d;
   logic [3:0]  io_be_q, io_be_d;
   logic [31:0] io_data_q, io_data_d;
   logic [1:0]  ld_off_q;
   size_t       ld_size_q;
   logic        ld_uns_q;
   logic        dm_rvalid_q;
   logic        align_err_q;
   logic [31:0] ram_rd_q;
   logic [31:0] mem_q [DM_WORDS];

   assign off        = addr[1:0];
   assign size       = is_byte ? SZ_BYTE : (is_half ? SZ_HALF : SZ_WORD);
   assign misaligned = (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
   assign in_dm      = addr[15:0] < IO_BASE;
   // Gated by rstn so a reset during a held IO request drops stall at once
   // instead of waiting for the pipeline to withdraw req_valid.
   assign accept     = rstn && req_valid && state_q == IDLE && !misaligned;
   assign dm_acc     = accept && in_dm;
   assign io_start   = accept && !in_dm;
   assign lane_data  = wdata << {off, 3'b000};
   assign dm_idx     = addr[DM_AW+1:2];

   // Byte enables from access size and offset
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      be = 4'b1111;
      case (size)
         SZ_BYTE: be = 4'b0001 << off;
         SZ_HALF: be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
   end

   // Data RAM: byte-masked write and synchronous read
   // NOTE: the RAM array has no reset so it maps onto block RAM; only control state is reset.
   always_ff @(posedge clk) begin
      if (dm_acc) begin
         if (mem_write) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) mem_q[dm_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
         end else begin
            ram_rd_q <= mem_q[dm_idx];
         end
      end
   end

   // Load context, DM read-valid and misalignment pulses
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ld_off_q    <= 2'b00;
         ld_size_q   <= SZ_WORD;
         ld_uns_q    <= 1'b0;
         dm_rvalid_q <= 1'b0;
         align_err_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         if (accept) begin
            ld_off_q  <= off;
            ld_size_q <= size;
            ld_uns_q  <= is_unsigned;
         end
         dm_rvalid_q <= dm_acc && !mem_write;
         align_err_q <= req_valid && state_q == IDLE && misaligned;
      end
   end

   // FSM state register and IO bus registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         to_q       <= 1'b0;
         io_req_q   <= 1'b0;
         io_we_q    <= 1'b0;
         io_addr_q  <= '0;
         io_wdata_q <= '0;
         io_be_q    <= '0;
         io_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         to_q       <= to_d;
         io_req_q   <= io_req_d;
         io_we_q    <= io_we_d;
         io_addr_q  <= io_addr_d;
         io_wdata_q <= io_wdata_d;
         io_be_q    <= io_be_d;
         io_data_q  <= io_data_d;
      end
   end

   // FSM next state: issue, wait for ack or timeout, retire
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      to_d       = to_q;
      io_req_d   = io_req_q;
      io_we_d    = io_we_q;
      io_addr_d  = io_addr_q;
      io_wdata_d = io_wdata_q;
      io_be_d    = io_be_q;
      io_data_d  = io_data_q;
      case (state_q)
         IDLE: begin
            if (io_start) begin
               state_d    = IO_BUSY;
               cnt_d      = '0;
               to_d       = 1'b0;
               io_req_d   = 1'b1;
               io_we_d    = mem_write;
               io_addr_d  = addr[31:2];
               io_wdata_d = lane_data;
               io_be_d    = be;
            end
         end
         IO_BUSY: begin
            cnt_d = cnt_q + 1'b1;
            // Ack wins over expiry in the same cycle.
            if (io.io_ack) begin
               io_data_d = io.io_rdata;
               io_req_d  = 1'b0;
               state_d   = IO_DONE;
            end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
               io_data_d = '0;
               io_req_d  = 1'b0;
               to_d      = 1'b1;
               state_d   = IO_DONE;
            end
         end
         IO_DONE: begin
            cnt_d   = '0;
            to_d    = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: stall, pulses and extended load data
   always_comb begin
      stall       = (state_q == IDLE && io_start) || state_q == IO_BUSY;
      io_timeout  = state_q == IO_DONE && to_q;
      rdata_valid = dm_rvalid_q || (state_q == IO_DONE && !io_we_q);
      rdata       = '0;
      if (rdata_valid) begin
         rdata = extract((state_q == IO_DONE) ? io_data_q : ram_rd_q, ld_off_q, ld_size_q, ld_uns_q);
      end
   end

   assign align_err   = align_err_q;
   assign io.io_req   = io_req_q;
   assign io.io_we    = io_we_q;
   assign io.io_addr  = io_addr_q;
   assign io.io_wdata = io_wdata_q;
   assign io.io_be    = io_be_q;

endmodule

// File: tb/tb_mem_access_stall_unit.sv
// Bench for mem_access_stall_unit: table of back-to-back DM accesses,
// hand-written IO sequences (ack, timeout, ack at expiry, reset mid-busy),
// and a scoreboard queue of expected load data popped on rdata_valid.
module tb_mem_access_stall_unit;

   localparam int TO = 15;

   typedef struct {
      logic        valid;
      logic        we;
      logic        bt;
      logic        hf;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_align;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_valid = 1'b0;
   logic        mem_write = 1'b0;
   logic        is_byte = 1'b0;
   logic        is_half = 1'b0;
   logic        is_unsigned = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        stall;
   logic        rdata_valid;
   logic [31:0] rdata;
   logic        align_err;
   logic        io_timeout;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] sb_q[$];
   vec_t vecs[$];

   mem_access_stall_unit_if io_bus ();

   mem_access_stall_unit dut (
      .clk         (clk),
      .rstn        (rstn),
      .req_valid   (req_valid),
      .mem_write   (mem_write),
      .is_byte     (is_byte),
      .is_half     (is_half),
      .is_unsigned (is_unsigned),
      .addr        (addr),
      .wdata       (wdata),
      .stall       (stall),
      .rdata_valid (rdata_valid),
      .rdata       (rdata),
      .align_err   (align_err),
      .io          (io_bus),
      .io_timeout  (io_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic v, we, bt, hf, uns, input logic [31:0] a, wd,
                               input logic [31:0] er, input logic ea);
      vec_t r;
      r.valid = v; r.we = we; r.bt = bt; r.hf = hf; r.uns = uns;
      r.addr = a; r.wdata = wd; r.exp_rdata = er; r.exp_align = ea;
      return r;
   endfunction

   task automatic drive(input logic v, we, bt, hf, uns, input logic [31:0] a, wd);
      req_valid = v; mem_write = we; is_byte = bt; is_half = hf; is_unsigned = uns;
      addr = a; wdata = wd;
   endtask

   // Scoreboard: every load result must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rstn && rdata_valid) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_rdata_valid", 32'd1, 32'd0);
         end else begin
            check("sb_rdata", rdata, sb_q.pop_front());
         end
      end
   end

   task automatic io_txn(input string name, input logic we, bt, hf, uns,
                         input logic [31:0] a, wd, input int ack_cyc, input logic [31:0] ack_data,
                         input logic [29:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic exp_to, input logic [31:0] exp_rd);
      int busy;
      busy = (ack_cyc > 0) ? ack_cyc : TO;
      @(negedge clk);
      drive(1'b1, we, bt, hf, uns, a, wd);
      if (!we) sb_q.push_back(exp_rd);
      #1;
      check({name, "_stall_issue"}, {31'd0, stall}, 32'd1);
      for (int k = 1; k <= busy; k++) begin
         @(negedge clk);
         check({name, "_stall_busy"}, {31'd0, stall}, 32'd1);
         check({name, "_io_req_busy"}, {31'd0, io_bus.io_req}, 32'd1);
         if (k == 1) begin
            check({name, "_io_we"}, {31'd0, io_bus.io_we}, {31'd0, we});
            check({name, "_io_addr"}, {2'b00, io_bus.io_addr}, {2'b00, exp_addr});
            check({name, "_io_be"}, {28'd0, io_bus.io_be}, {28'd0, exp_be});
            check({name, "_io_wdata"}, io_bus.io_wdata, exp_wdata);
         end
         if (k == ack_cyc) begin
            io_bus.io_ack = 1'b1;
            io_bus.io_rdata = ack_data;
         end
      end
      @(negedge clk);
      io_bus.io_ack = 1'b0;
      io_bus.io_rdata = 32'h5A5A_A5A5;
      check({name, "_stall_done"}, {31'd0, stall}, 32'd0);
      check({name, "_io_req_done"}, {31'd0, io_bus.io_req}, 32'd0);
      check({name, "_io_timeout"}, {31'd0, io_timeout}, {31'd0, exp_to});
      req_valid = 1'b0;
      @(negedge clk);
      check({name, "_io_timeout_clear"}, {31'd0, io_timeout}, 32'd0);
      check({name, "_stall_idle"}, {31'd0, stall}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      io_bus.io_ack = 1'b0;
      io_bus.io_rdata = '0;

      //                v     we    byte  half  uns   addr          wdata         exp_rdata     align
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h0,         32'hFFFF_FFDE, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0013, 32'h0,         32'h0000_00DE, 1'b0));
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'h0,        1'b0));
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0022, 32'h0000_1234, 32'h0,        1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'h1234_0000, 1'b0));
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0030, 32'hCAFE_F00D, 32'h0,        1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0031, 32'h0,         32'h0,        1'b1));
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0031, 32'h1111_1111, 32'h0,        1'b1));
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0030, 32'h0,         32'h0,        1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0030, 32'h0,         32'hCAFE_F00D, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0032, 32'h0,         32'hFFFF_CAFE, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0030, 32'h0,         32'h0000_F00D, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0011, 32'h0,         32'hFFFF_FFBE, 1'b0));
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0012, 32'h0000_0077, 32'h0,        1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDE77_BEEF, 1'b0));
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2FFC, 32'h0BAD_CAFE, 32'h0,        1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2FFC, 32'h0,         32'h0BAD_CAFE, 1'b0));

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_align_err", {31'd0, align_err}, 32'd0);
      check("rst_io_req", {31'd0, io_bus.io_req}, 32'd0);
      check("rst_io_we", {31'd0, io_bus.io_we}, 32'd0);
      check("rst_io_addr", {2'b00, io_bus.io_addr}, 32'd0);
      check("rst_io_wdata", io_bus.io_wdata, 32'd0);
      check("rst_io_be", {28'd0, io_bus.io_be}, 32'd0);
      check("rst_io_timeout", {31'd0, io_timeout}, 32'd0);
      rstn = 1'b1;

      // Back-to-back DM accesses, one per cycle
      @(negedge clk);
      foreach (vecs[i]) begin
         drive(vecs[i].valid, vecs[i].we, vecs[i].bt, vecs[i].hf, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
         if (vecs[i].valid && !vecs[i].we && !vecs[i].exp_align) sb_q.push_back(vecs[i].exp_rdata);
         @(negedge clk);
         check($sformatf("vec%0d_align_err", i), {31'd0, align_err}, {31'd0, vecs[i].exp_align});
         check($sformatf("vec%0d_stall", i), {31'd0, stall}, 32'd0);
      end
      req_valid = 1'b0;
      @(negedge clk);

      // io_ack outside IO_BUSY is ignored
      io_bus.io_ack = 1'b1;
      io_bus.io_rdata = 32'hFFFF_FFFF;
      repeat (3) begin
         @(negedge clk);
         check("stray_ack_io_req", {31'd0, io_bus.io_req}, 32'd0);
         check("stray_ack_stall", {31'd0, stall}, 32'd0);
         check("stray_ack_timeout", {31'd0, io_timeout}, 32'd0);
      end
      io_bus.io_ack = 1'b0;

      // IO byte store, ack in the 3rd busy cycle
      io_txn("io_sb", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3005, 32'h0000_00AB, 3, 32'h0,
             30'h0000_0C01, 4'b0010, 32'h0000_AB00, 1'b0, 32'h0);
      // IO word load, no ack: timeout returns zero
      io_txn("io_lw_to", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_4000, 32'h0, 0, 32'h0,
             30'h0000_1000, 4'b1111, 32'h0, 1'b1, 32'h0);
      // IO word load, ack on the expiry cycle counts as ack
      io_txn("io_lw_ack15", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_4000, 32'h0, TO, 32'h1357_9BDF,
             30'h0000_1000, 4'b1111, 32'h0, 1'b0, 32'h1357_9BDF);
      // IO unsigned upper-half load
      io_txn("io_lhu", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3002, 32'h0, 1, 32'h8001_1234,
             30'h0000_0C00, 4'b1100, 32'h0, 1'b0, 32'h0000_8001);

      // Reset during IO_BUSY abandons the transaction
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3100, 32'h0);
      repeat (2) @(negedge clk);
      check("rst_busy_io_req_before", {31'd0, io_bus.io_req}, 32'd1);
      #2 rstn = 1'b0;
      #1;
      check("rst_busy_io_req", {31'd0, io_bus.io_req}, 32'd0);
      check("rst_busy_stall", {31'd0, stall}, 32'd0);
      req_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
      sb_q.push_back(32'hDE77_BEEF);
      @(negedge clk);
      check("post_rst_stall", {31'd0, stall}, 32'd0);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);

      check("sb_drained", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
